blk_sender: RTL and testbench

BLK_SENDER -- requirements
Module: blk_sender

---
 rtl/blk_sender.sv | 125 ++++++++++++
 tb/tb_blk_sender.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_sender.sv
// Block-oriented channel sender: buffers words from a block builder, commits whole
// blocks, and hands them to a link arbiter one word per grant.
module blk_sender #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   wr_data,
  input  logic          wr_en,
  input  logic          wr_last,
  output logic          req,
  input  logic          ack,
  output logic [15:0]   data,
  output logic [AW:0]   blk_cnt,
  output logic [15:0]   drop_cnt,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [16:0]   mem_r [DEPTH];
  logic [AW-1:0] wp_r, cp_r, rp_r, wp_s, cp_s, rp_s, wp_inc_s;
  logic          drop_r, drop_s;
  logic          full_s, wr_ok_s, commit_s, ovf_s, grant_s, done_s;
  logic          req_s, empty_s;
  logic [AW:0]   blk_s;
  logic [15:0]   drop_cnt_s, data_s;

  // Write side: accept, commit or discard the incoming word.
  always_comb begin
    wp_inc_s = wp_r + PTR_ONE;
    full_s   = (wp_inc_s == rp_r);
    wp_s     = wp_r;
    cp_s     = cp_r;
    drop_s   = drop_r;
    wr_ok_s  = 1'b0;
    commit_s = 1'b0;
    ovf_s    = 1'b0;
    if (wr_en) begin
      if (drop_r) begin
        drop_s = ~wr_last;
      end else if (full_s) begin
        ovf_s  = 1'b1;
        wp_s   = cp_r;
        drop_s = ~wr_last;
      end else begin
        wr_ok_s  = 1'b1;
        wp_s     = wp_inc_s;
        commit_s = wr_last;
        if (wr_last) cp_s = wp_inc_s;
        else         cp_s = cp_r;
      end
    end else begin
      wp_s = wp_r;
    end
  end

  // Read FSM next state; GAP jumps straight to SEND when another block waits,
  // so consecutive blocks are separated by exactly one low req cycle.
  always_comb begin
    grant_s = (state_r == SEND) & ack;
    done_s  = grant_s & mem_r[rp_r][16];
    rp_s    = grant_s ? (rp_r + PTR_ONE) : rp_r;
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = (|blk_cnt) ? SEND : IDLE;
      SEND:    state_s = done_s ? GAP : SEND;
      GAP:     state_s = (|blk_cnt) ? SEND : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    req_s = (state_s == SEND);
    case ({commit_s, done_s})
      2'b10:   blk_s = blk_cnt + CNT_ONE;
      2'b01:   blk_s = blk_cnt - CNT_ONE;
      default: blk_s = blk_cnt;
    endcase
    if (ovf_s && (drop_cnt != 16'hFFFF)) drop_cnt_s = drop_cnt + 16'd1;
    else                                 drop_cnt_s = drop_cnt;
    if (grant_s) data_s = mem_r[rp_r][15:0];
    else         data_s = data;
    empty_s = (wp_s == rp_s);
  end

  // State, pointers and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      wp_r     <= {AW{1'b0}};
      cp_r     <= {AW{1'b0}};
      rp_r     <= {AW{1'b0}};
      drop_r   <= 1'b0;
      blk_cnt  <= {(AW+1){1'b0}};
      drop_cnt <= 16'h0000;
      req      <= 1'b0;
      data     <= 16'h0000;
      empty    <= 1'b1;
    end else begin
      state_r  <= state_s;
      wp_r     <= wp_s;
      cp_r     <= cp_s;
      rp_r     <= rp_s;
      drop_r   <= drop_s;
      blk_cnt  <= blk_s;
      drop_cnt <= drop_cnt_s;
      req      <= req_s;
      data     <= data_s;
      empty    <= empty_s;
    end
  end

  // Buffer storage; contents survive reset, pointers make them invisible.
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem_r[wp_r] <= {wr_last, wr_data};
  end

endmodule

// File: tb/tb_blk_sender.sv
// Self-checking bench for blk_sender (AW = 4): directed tables and sequences plus
// randomized traffic against a queue-based reference model.
module tb_blk_sender;

  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk, reset, wr_en, wr_last, ack;
  logic [15:0] wr_data;
  logic        req, empty;
  logic [15:0] data, drop_cnt;
  logic [AW:0] blk_cnt;

  blk_sender #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .wr_last(wr_last),
    .req(req), .ack(ack), .data(data), .blk_cnt(blk_cnt), .drop_cnt(drop_cnt),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model: all unread words in order, partial block at the tail
  logic [16:0] m_q[$];
  int          m_part, m_blk, m_drop_cnt;
  bit          m_drop, m_req;
  logic [15:0] m_data;
  logic [15:0] got[$];

  typedef struct {
    logic        we;
    logic        wl;
    logic [15:0] wd;
    logic        ak;
    logic        ereq;
    logic [15:0] edata;
    int          eblk;
    logic        eempty;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int sz;
    bit inc, dec, req_n;
    logic [16:0] w;
    if (reset) begin
      m_q.delete(); m_part = 0; m_blk = 0; m_drop_cnt = 0;
      m_drop = 0; m_req = 0; m_data = 16'h0000;
      return;
    end
    sz = m_q.size(); inc = 0; dec = 0; req_n = m_req;
    if (m_req && ack) begin
      w = m_q.pop_front();
      m_data = w[15:0];
      if (w[16]) begin req_n = 0; dec = 1; end
    end else if (!m_req) begin
      req_n = (m_blk != 0);
    end
    if (wr_en) begin
      if (m_drop) begin
        if (wr_last) m_drop = 0;
      end else if (sz == DEPTH - 1) begin
        repeat (m_part) void'(m_q.pop_back());
        m_part = 0;
        if (m_drop_cnt < 65535) m_drop_cnt++;
        m_drop = !wr_last;
      end else begin
        m_q.push_back({wr_last, wr_data});
        if (wr_last) begin m_part = 0; inc = 1; end
        else m_part++;
      end
    end
    m_blk = m_blk + int'(inc) - int'(dec);
    m_req = req_n;
  endtask

  // one clock: update model, advance, capture granted word, compare with model
  task automatic step();
    logic p;
    p = req & ack & ~reset;
    model_edge();
    @(posedge clk);
    #1;
    if (p) got.push_back(data);
    chk("m_req", req, m_req);
    chk("m_data", data, m_data);
    chk("m_blk", blk_cnt, m_blk);
    chk("m_drop", drop_cnt, m_drop_cnt);
    chk("m_empty", empty, m_q.size() == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; wr_last = 1'b0;
    step();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic wr_word(input logic [15:0] d, input logic l);
    wr_en = 1'b1; wr_data = d; wr_last = l;
    step();
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  int          k, pulses, runlen, lows;
  logic        tr[20];
  logic        prv;
  logic [15:0] exp34[6];

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_last = 1'b0; wr_data = 16'h0000; ack = 1'b0;
    do_reset();
    chk("rst_req", req, 1'b0);
    chk("rst_blk", blk_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_data", data, 16'h0000);

    // single 4-word block, ack held high
    tbl[0]  = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h0000, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'h2222, 1'b1, 1'b0, 16'h0000, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h3333, 1'b1, 1'b0, 16'h0000, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16'h4444, 1'b1, 1'b0, 16'h0000, 1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1111, 1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2222, 1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h3333, 1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4444, 0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4444, 0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4444, 0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      wr_en = tbl[i].we; wr_last = tbl[i].wl; wr_data = tbl[i].wd; ack = tbl[i].ak;
      step();
      chk("t4_req", req, tbl[i].ereq);
      chk("t4_data", data, tbl[i].edata);
      chk("t4_blk", blk_cnt, tbl[i].eblk);
      chk("t4_empty", empty, tbl[i].eempty);
    end
    wr_en = 1'b0; wr_last = 1'b0;

    // three queued 2-word blocks: pulses of 2, single low cycle between
    do_reset();
    ack = 1'b1;
    exp34 = '{16'hA001, 16'hA002, 16'hB001, 16'hB002, 16'hC001, 16'hC002};
    k = 0;
    for (int i = 0; i < 6; i++) begin
      wr_word(exp34[i], 1'(i % 2));
      tr[k] = req; k++;
    end
    for (int i = 0; i < 14; i++) begin
      step();
      tr[k] = req; k++;
    end
    pulses = 0; runlen = 0; lows = 0; prv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tr[i]) begin
        if (!prv && pulses > 0) chk("q3_gap", lows, 1);
        runlen++;
      end else begin
        if (prv) begin chk("q3_len", runlen, 2); pulses++; runlen = 0; lows = 0; end
        lows++;
      end
      prv = tr[i];
    end
    chk("q3_pulses", pulses, 3);
    chk("q3_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("q3_word", got[i], exp34[i]);

    // ack stalled for 10 cycles mid-block
    do_reset();
    ack = 1'b0;
    for (int i = 0; i < 4; i++) wr_word(16'hD001 + 16'(i), 1'(i == 3));
    for (int i = 0; i < 10 && !req; i++) step();
    chk("st_req_up", req, 1'b1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("st_first", data, 16'hD001);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("st_hold_req", req, 1'b1);
      chk("st_hold_data", data, 16'hD001);
    end
    ack = 1'b1;
    for (int i = 0; i < 10 && req; i++) step();
    chk("st_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("st_word", got[i], 16'hD001 + 16'(i));

    // overflow: second 10-word block dropped, later 3-word block accepted
    do_reset();
    ack = 1'b0;
    for (int i = 0; i < 10; i++) wr_word(16'hE000 + 16'(i), 1'(i == 9));
    for (int i = 0; i < 10; i++) wr_word(16'hF000 + 16'(i), 1'(i == 9));
    chk("ov_blk1", blk_cnt, 1);
    chk("ov_drop", drop_cnt, 1);
    for (int i = 0; i < 3; i++) wr_word(16'h9000 + 16'(i), 1'(i == 2));
    chk("ov_blk2", blk_cnt, 2);
    ack = 1'b1;
    for (int i = 0; i < 40 && !(blk_cnt == 0 && !req); i++) step();
    chk("ov_count", got.size(), 13);
    for (int i = 0; i < 13 && i < got.size(); i++)
      chk("ov_word", got[i], (i < 10) ? (16'hE000 + 16'(i)) : (16'h9000 + 16'(i - 10)));

    // commit coinciding with the last-word grant of another block
    do_reset();
    ack = 1'b0;
    wr_word(16'h7001, 1'b0);
    wr_word(16'h7002, 1'b1);
    ack = 1'b1;
    step();
    chk("co_req", req, 1'b1);
    wr_word(16'h8001, 1'b0);
    chk("co_blk_a", blk_cnt, 1);
    wr_word(16'h8002, 1'b1);
    chk("co_blk_b", blk_cnt, 1);
    chk("co_req_low", req, 1'b0);
    chk("co_data", data, 16'h7002);
    for (int i = 0; i < 10 && blk_cnt != 0; i++) step();
    chk("co_count", got.size(), 4);

    // randomized traffic against the model
    do_reset();
    begin
      int thr;
      thr = 7;
      for (int c = 0; c < 4000; c++) begin
        if (c % 150 == 0) thr = $urandom_range(0, 10);
        wr_en   = 1'($urandom_range(0, 1));
        wr_last = ($urandom_range(0, 5) == 0);
        wr_data = 16'($urandom);
        ack     = ($urandom_range(0, 9) < thr);
        reset   = ($urandom_range(0, 999) == 0);
        step();
      end
      reset = 1'b0;
    end

    // reset during SEND after 2 of 5 words, with a prior drop recorded
    do_reset();
    ack = 1'b0;
    for (int i = 0; i < 16; i++) wr_word(16'h5000 + 16'(i), 1'b0);
    wr_word(16'h5FFF, 1'b1);
    chk("rs_drop_pre", drop_cnt, 1);
    chk("rs_empty_pre", empty, 1'b1);
    for (int i = 0; i < 5; i++) wr_word(16'h6000 + 16'(i), 1'(i == 4));
    ack = 1'b1;
    got.delete();
    for (int i = 0; i < 20 && got.size() < 2; i++) step();
    chk("rs_two", got.size(), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rs_req", req, 1'b0);
    chk("rs_blk", blk_cnt, 0);
    chk("rs_empty", empty, 1'b1);
    chk("rs_drop", drop_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
